// File: rtl/sdram_sim_pkg.sv
// Shared state encoding and default latencies for the SDRAM controller model.
package sdram_sim_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_REF
    } state_t;

    localparam int unsigned DEF_MEM_SIZE    = 65536;
    localparam int unsigned DEF_RD_LAT      = 4;
    localparam int unsigned DEF_WR_LAT      = 4;
    localparam int unsigned DEF_REF_LAT     = 8;
    localparam int unsigned DEF_INIT_CYCLES = 16;
    localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/sdram_sim_mem.sv
// Byte-lane storage: 4-lane masked word write, combinational word read.
module sdram_sim_mem
    import sdram_sim_pkg::*;
#(
    parameter int unsigned MEM_SIZE = DEF_MEM_SIZE,
    localparam int unsigned AW      = $clog2(MEM_SIZE) - 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wmask,
    output logic [31:0]   rdata
);

    logic [7:0] mem [0:MEM_SIZE-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[{addr, 2'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = {mem[{addr, 2'd3}], mem[{addr, 2'd2}], mem[{addr, 2'd1}], mem[{addr, 2'd0}]};

endmodule

// File: rtl/sdram_sim_ctrl.sv
// Cycle-approximate SDRAM controller model with a single word port and busy handshake.
// Optional feature: define SDRAM_REFRESH_EN to honour the refresh request.
module sdram_sim_ctrl
    import sdram_sim_pkg::*;
#(
    parameter int unsigned MEM_SIZE    = DEF_MEM_SIZE,
    parameter int unsigned RD_LAT      = DEF_RD_LAT,
    parameter int unsigned WR_LAT      = DEF_WR_LAT,
    parameter int unsigned REF_LAT     = DEF_REF_LAT,
    parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_a,
    input  logic        write,
    input  logic        refresh,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  mask,
    output logic [31:0] dout_a,
    output logic        busy,
    output logic        mem_initialized
);

    localparam int unsigned AW = $clog2(MEM_SIZE) - 2;

`ifdef SDRAM_REFRESH_EN
    localparam bit REFRESH_EN = 1'b1;
`else
    localparam bit REFRESH_EN = 1'b0;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    a_q;
    logic [31:0]      d_q;
    logic [3:0]       m_q;
    logic [31:0]      rdata;
    logic             we_c;
    logic             unused_bits;

    // Byte offset and out-of-range address bits are dropped (alignment and wrap).
    assign unused_bits = ^{addr[1:0], addr[31:AW+2]};

    // Commit on the final WR cycle unless reset aborts the op on that same edge.
    assign we_c = (state == ST_WR) && (cnt == '0) && !rst;

    sdram_sim_mem #(.MEM_SIZE(MEM_SIZE)) idbmem (
        .clk   (clk),
        .we    (we_c),
        .addr  (a_q),
        .wdata (d_q),
        .wmask (m_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_INIT;
            busy            <= 1'b1;
            mem_initialized <= 1'b0;
            dout_a          <= '0;
            cnt             <= CNT_W'(INIT_CYCLES - 1);
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == '0) begin
                        state           <= ST_IDLE;
                        busy            <= 1'b0;
                        mem_initialized <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_IDLE: begin
                    // Latching here is harmless when idle; only an accepted op uses it.
                    a_q <= addr[AW+1:2];
                    d_q <= din;
                    m_q <= mask;
                    if (read_a) begin
                        state <= ST_RD;
                        busy  <= 1'b1;
                        cnt   <= CNT_W'(RD_LAT - 1);
                    end else if (write) begin
                        state <= ST_WR;
                        busy  <= 1'b1;
                        cnt   <= CNT_W'(WR_LAT - 1);
                    end else if (REFRESH_EN && refresh) begin
                        state <= ST_REF;
                        busy  <= 1'b1;
                        cnt   <= CNT_W'(REF_LAT - 1);
                    end
                end
                ST_RD, ST_WR, ST_REF: begin
                    if (cnt == '0) begin
                        if (state == ST_RD) dout_a <= rdata;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_sim_ctrl.sv
// Scoreboard bench for sdram_sim_ctrl: expected read data queued at issue, checked at completion.
module tb_sdram_sim_ctrl;

    localparam int unsigned MEM_SIZE = 65536;
    localparam int unsigned RD_LAT   = 4;
    localparam int unsigned WR_LAT   = 4;
    localparam int unsigned REF_LAT  = 8;
    localparam int unsigned INIT_CYC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_a = 1'b0;
    logic        write = 1'b0;
    logic        refresh = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  mask = '0;
    logic [31:0] dout_a;
    logic        busy;
    logic        mem_initialized;

    int          vectors = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  model [int];

    sdram_sim_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .read_a          (read_a),
        .write           (write),
        .refresh         (refresh),
        .addr            (addr),
        .din             (din),
        .mask            (mask),
        .dout_a          (dout_a),
        .busy            (busy),
        .mem_initialized (mem_initialized)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int base_of(input logic [31:0] a);
        return int'((a & 32'(MEM_SIZE - 1)) & ~32'd3);
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int b;
        b = base_of(a);
        for (int i = 0; i < 4; i++) if (m[i]) model[b + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int b;
        logic [31:0] r;
        b = base_of(a);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = model.exists(b + i) ? model[b + i] : 8'h00;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for busy to rise after a request is raised.
    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 20);
        if (!busy) check({tag, "_accept_timeout"}, 32'(busy), 32'd1);
    endtask

    // Count cycles busy is seen high, starting at the current sample.
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a);
        int n;
        addr = a;
        read_a = 1'b1;
        exp_q.push_back(model_rd(a));
        wait_busy(tag);
        read_a = 1'b0;
        count_busy(n);
        check({tag, "_rd_busy_len"}, 32'(n), 32'(RD_LAT));
        check({tag, "_rdata"}, dout_a, exp_q.pop_front());
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] m);
        int n;
        addr = a;
        din = d;
        mask = m;
        write = 1'b1;
        model_wr(a, d, m);
        wait_busy(tag);
        write = 1'b0;
        count_busy(n);
        check({tag, "_wr_busy_len"}, 32'(n), 32'(WR_LAT));
    endtask

    task automatic check_init(input string tag);
        int n;
        count_busy(n);
        check({tag, "_init_len"}, 32'(n), 32'(INIT_CYC));
        check({tag, "_initialized"}, 32'(mem_initialized), 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_init", 32'(mem_initialized), 32'd0);
        check("rst_dout", dout_a, 32'h0);

        // read held through init must not be served
        read_a = 1'b1;
        addr = 32'h100;
        rst = 1'b0;
        check_init("init");
        read_a = 1'b0;
        tick();
        check("init_read_ignored", 32'(busy), 32'd0);
        check("init_dout", dout_a, 32'h0);

        do_write("word", 32'h100, 32'hDEADBEEF, 4'hF);
        do_read("word", 32'h100);

        do_write("lane_pre", 32'h200, 32'h11223344, 4'hF);
        do_write("lane", 32'h200, 32'h0000AA00, 4'b0010);
        do_read("lane", 32'h200);
        check("lane_const", model_rd(32'h200), 32'h1122AA44);
        do_write("unalign", 32'h203, 32'h55667788, 4'hF);
        do_read("unalign", 32'h200);
        do_write("mask0", 32'h100, 32'h01010101, 4'h0);
        do_read("mask0", 32'h100);

        // all three requests in one idle cycle
        addr = 32'h100;
        din = 32'hCAFEF00D;
        mask = 4'hF;
        read_a = 1'b1;
        write = 1'b1;
        refresh = 1'b1;
        exp_q.push_back(model_rd(32'h100));
        wait_busy("prio_rd");
        read_a = 1'b0;
        count_busy(n);
        check("prio_rd_len", 32'(n), 32'(RD_LAT));
        check("prio_rd_first", dout_a, exp_q.pop_front());
        model_wr(32'h100, 32'hCAFEF00D, 4'hF);
        wait_busy("prio_wr");
        write = 1'b0;
        count_busy(n);
        check("prio_wr_len", 32'(n), 32'(WR_LAT));
`ifdef SDRAM_REFRESH_EN
        wait_busy("prio_ref");
        refresh = 1'b0;
        count_busy(n);
        check("prio_ref_len", 32'(n), 32'(REF_LAT));
`else
        repeat (3) tick();
        check("ref_ignored", 32'(busy), 32'd0);
        refresh = 1'b0;
`endif
        do_read("prio_after", 32'h100);

        do_write("wrap", 32'(MEM_SIZE + 4), 32'h0BADCAFE, 4'hF);
        do_read("wrap", 32'h4);

        // inputs changed after acceptance must not leak into the op
        do_write("hold_pre", 32'h304, 32'h01020304, 4'hF);
        addr = 32'h300;
        din = 32'hA5A5A5A5;
        mask = 4'hF;
        write = 1'b1;
        model_wr(32'h300, 32'hA5A5A5A5, 4'hF);
        wait_busy("hold");
        write = 1'b0;
        addr = 32'h304;
        din = 32'h0;
        mask = 4'h0;
        count_busy(n);
        check("hold_len", 32'(n), 32'(WR_LAT));
        do_read("hold_a", 32'h300);
        do_read("hold_b", 32'h304);

        // reset two cycles into a write aborts it
        addr = 32'h100;
        din = 32'h12345678;
        mask = 4'hF;
        write = 1'b1;
        wait_busy("abort");
        write = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_dout", dout_a, 32'h0);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_init", 32'(mem_initialized), 32'd0);
        rst = 1'b0;
        check_init("reinit");
        do_read("abort", 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
